// File: rtl/ecc_dma_engine.sv
// Operand-transfer sequencer: streams RAM A/B words through the field ALU or an
// internal XOR/copy path into RAM C/D. Optional macro ECC_DMA_ALU_REG_EN adds an AW state.
module ecc_dma_engine #(
  parameter int DATA = 256,
  parameter int ADDR = 3,
  parameter int OPW  = 136
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [ADDR-1:0]   src_a,
  input  logic [ADDR-1:0]   src_b,
  input  logic [ADDR-1:0]   dst,
  input  logic              dst_sel,
  input  logic [ADDR:0]     len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR-1:0]   rd_addr_a,
  output logic [ADDR-1:0]   rd_addr_b,
  input  logic [DATA-1:0]   rd_data_a,
  input  logic [DATA-1:0]   rd_data_b,
  output logic [OPW-1:0]    alu_a,
  output logic [OPW-1:0]    alu_b,
  output logic [2:0]        alu_sel,
  input  logic [DATA-1:0]   alu_res,
  output logic              wr_en_c,
  output logic              wr_en_d,
  output logic [ADDR-1:0]   wr_addr,
  output logic [DATA-1:0]   wr_data
);
  localparam int HALF = DATA / 2;
  localparam logic [2:0] OP_MUL  = 3'b001;
  localparam logic [2:0] OP_SQR  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b111;
  localparam logic [2:0] OP_COPY = 3'b101;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_EX, S_AW, S_WR, S_DONE} state_t;
  state_t state, next;

  logic [2:0]      op_q;
  logic [ADDR-1:0] src_a_q, src_b_q, dst_q, wr_idx_q;
  logic            dst_sel_q, pass_q, err_q;
  logic [ADDR:0]   len_q, idx_q;
  logic [DATA-1:0] res_q, res_next, sqr_word;
  logic [HALF-1:0] half;
  logic            legal_in, accept, last_write, opnd_phase, cap_phase;

  assign legal_in = (op == OP_MUL) || (op == OP_SQR) || (op == OP_XOR) || (op == OP_COPY);
  assign accept   = (state == S_IDLE) && start;
  // SQR pass 0 re-reads the same word for pass 1, so it is never the last write
  assign last_write = !((op_q == OP_SQR) && !pass_q) && ((idx_q + 1'b1) == len_q);

`ifdef ECC_DMA_ALU_REG_EN
  // operands held across EX and AW; ALU result sampled at the end of AW
  assign opnd_phase = (state == S_EX) || (state == S_AW);
  assign cap_phase  = (state == S_AW);
`else
  assign opnd_phase = (state == S_EX);
  assign cap_phase  = (state == S_EX);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      S_IDLE: if (start) next = (!legal_in || len == '0) ? S_DONE : S_RD;
      S_RD:   next = S_EX;
`ifdef ECC_DMA_ALU_REG_EN
      S_EX:   next = S_AW;
`else
      S_EX:   next = S_WR;
`endif
      S_AW:   next = S_WR;
      S_WR:   next = last_write ? S_DONE : S_RD;
      S_DONE: next = S_IDLE;
      default: next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= '0; src_a_q <= '0; src_b_q <= '0; dst_q <= '0; dst_sel_q <= 1'b0;
      len_q <= '0; idx_q <= '0; wr_idx_q <= '0; pass_q <= 1'b0; err_q <= 1'b0;
      res_q <= '0;
    end else begin
      if (accept) begin
        op_q <= op; src_a_q <= src_a; src_b_q <= src_b; dst_q <= dst;
        dst_sel_q <= dst_sel; len_q <= len; idx_q <= '0; wr_idx_q <= '0;
        pass_q <= 1'b0; err_q <= !legal_in;
      end
      if (cap_phase) res_q <= res_next;
      if (state == S_WR) begin
        wr_idx_q <= wr_idx_q + 1'b1;
        if ((op_q == OP_SQR) && !pass_q) begin
          pass_q <= 1'b1;
        end else begin
          pass_q <= 1'b0;
          idx_q  <= idx_q + 1'b1;
        end
      end
    end
  end

  assign half     = pass_q ? rd_data_a[DATA-1:HALF] : rd_data_a[HALF-1:0];
  assign sqr_word = {{(DATA-HALF){1'b0}}, half};

  always_comb begin
    alu_a = '0;
    alu_b = '0;
    if (opnd_phase) begin
      case (op_q)
        OP_MUL: begin
          alu_a = rd_data_a[OPW-1:0];
          alu_b = rd_data_b[OPW-1:0];
        end
        OP_SQR:  alu_a = sqr_word[OPW-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    case (op_q)
      OP_XOR:  res_next = rd_data_a ^ rd_data_b;
      OP_COPY: res_next = rd_data_a;
      default: res_next = alu_res;
    endcase
  end

  assign rd_addr_a = src_a_q + idx_q[ADDR-1:0];
  assign rd_addr_b = src_b_q + idx_q[ADDR-1:0];
  assign alu_sel   = op_q;
  assign busy      = (state == S_RD) || (state == S_EX) || (state == S_AW) || (state == S_WR);
  assign done      = (state == S_DONE);
  assign err       = (state == S_DONE) && err_q;
  assign wr_en_c   = (state == S_WR) && !dst_sel_q;
  assign wr_en_d   = (state == S_WR) && dst_sel_q;
  assign wr_addr   = (state == S_WR) ? dst_q + wr_idx_q : '0;
  assign wr_data   = (state == S_WR) ? res_q : '0;
endmodule

// File: doc/ecc_dma_engine.md
# ecc_dma_engine

Parametrised operand-transfer sequencer for the GF(2^m) scalar-multiplication datapath. It accepts one command (op, source addresses, destination, length) and streams operand words from the A/B RAM read ports through the field-arithmetic unit or an internal XOR/copy path. Results are written back to RAM C or D. It replaces per-word host sequencing of the RAM interface with an autonomous multi-word burst that has a start/busy/done handshake.

## Interface
- DATA, 256, RAM word width in bits; must be even.
- ADDR, 3, RAM address width; depth 2^ADDR words.
- OPW, 136, operand width presented to the arithmetic unit; OPW ≤ DATA.

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  command strobe; sampled only in IDLE.
- op  in  3  3'b001 MUL, 3'b010 SQR, 3'b111 XOR, 3'b101 COPY.
- src_a, src_b  in  ADDR  first source addresses, RAM A / RAM B.
- dst  in  ADDR  first destination address.
- dst_sel  in  1  0 = RAM C, 1 = RAM D.
- len  in  ADDR+1  number of source words, 0..2^ADDR.
- busy  out  1  high from the cycle after start accept until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse coincident with done on an illegal op.
- rd_addr_a, rd_addr_b  out  ADDR  read addresses; RAM read latency is 1 cycle.
- rd_data_a, rd_data_b  in  DATA  read data.
- alu_a, alu_b  out  OPW  arithmetic-unit operands.
- alu_sel  out  3  arithmetic-unit select; equals the latched op.
- alu_res  in  DATA  arithmetic-unit result, combinational.
- wr_en_c, wr_en_d  out  1  write strobes.
- wr_addr  out  ADDR  write address.
- wr_data  out  DATA  write data.

## Operation
- Command latch: on start in IDLE, latch op, src_a, src_b, dst, dst_sel and len, and clear the word counter.
- States: IDLE → RD → EX → WR → RD (more words) | DONE → IDLE.
- RD: drive the read addresses.
- EX: read data is valid. Form the operands and register the result in the res register.
- WR: assert exactly one of wr_en_c/wr_en_d, chosen by dst_sel. Drive wr_addr = dst + write_index and wr_data = res. Then advance the pointers.
- MUL: alu_a = rd_data_a[OPW-1:0], alu_b = rd_data_b[OPW-1:0], res = alu_res. One write per source word.
- SQR: two passes per source word.
  - Pass 0 uses the lower half {zeros, rd_data_a[DATA/2-1:0]} and writes dst+2i.
  - Pass 1 uses the upper half and writes dst+2i+1.
  - The word is re-read for pass 1; 2·len writes total.
  - alu_b = 0.
- XOR: res = rd_data_a ^ rd_data_b, computed internally; the ALU is unused.
- COPY: res = rd_data_a, the RAM-swap path.
- Unused ALU operands are driven 0.
- Address wrap: all addresses increment modulo 2^ADDR; no error on wrap.
- len = 0: go IDLE → DONE. done is asserted with no read or write.
- Illegal op: go straight to DONE. done and err are both asserted, with no writes.
- start while busy: ignored; the command is not queued.
- Reset: asynchronous, in any state. Returns to IDLE and zeroes all outputs and registers; an in-flight burst is abandoned. A write strobe never extends past reset assertion.

## Timing
- Reset value of every output: 0.
- start is accepted at edge 0; busy rises after edge 0.
- Per word: 3 cycles, or 4 with ECC_DMA_ALU_REG_EN.
- First wr_en is high in cycle 3 after accept.
- done rises one cycle after the last WR, i.e. 3·N+1 cycles after accept (N = writes). busy falls in the same cycle done rises.
- done for len = 0 or an illegal op: 1 cycle after accept.
- A new start is accepted in the cycle after done.

## Configuration
- ECC_DMA_ALU_REG_EN defined:
  - Adds state AW between EX and WR, and registers alu_res for a two-cycle multicycle path.
  - Per word: 4 cycles; done arrives at 4·N+1 cycles. XOR and COPY also take 4 cycles.
- ECC_DMA_ALU_REG_EN undefined: alu_res is captured in EX, giving 3 cycles per word.

## Test plan
- MUL, len = 2, src_a = 0, src_b = 4, dst = 1, dst_sel = 0, ALU model returns a·b → exactly two wr_en_c pulses at wr_addr 1 and 2 carrying the model products; done at cycle 7.
- SQR, len = 1, A[3] = {128'hF…F, 128'h1} → writes to dst and dst+1 with lower-half and upper-half squares; alu_a bits above DATA/2 are 0 on both passes.
- XOR, len = 8, src_a = 5, src_b = 0, dst = 6, dst_sel = 1 → addresses wrap 7→0; each written word is A ^ B; 8 wr_en_d pulses; wr_en_c never asserted.
- op = 3'b000 and a separate command with len = 0 → done after 1 cycle, err only for the illegal op, no write strobes.
- start reasserted mid-burst → ignored and the result is unchanged. rst_n pulled low during WR → wr_en drops asynchronously, all outputs read 0, and the next command runs normally.
- With ECC_DMA_ALU_REG_EN, repeat the MUL case → done at cycle 9 with identical data.
